dmem_responder: RTL and testbench

Word-addressed data-memory responder that serves the CPU's load/store port through a valid/ready request–response handshake with a configurable number of wait states. It sits at the memory end of the MEM-stage data interface: the pipeline is the initiator and this block is the responder. It replaces the zero-latency data-memory model so that stall-capable pipeline logic can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types and widths for the data-memory responder     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_pkg;

  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array : single-port synchronous RAM, byte write enables,        |
// | read-before-write, no reset.  Rev 1.0                                |
// +----------------------------------------------------------------------+
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // rdata_q only moves on an access, so it holds the last word for the response.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder : valid/ready data-memory responder, WAIT_CYCLES      |
// | wait states between accept and response.  Rev 1.0                    |
// +----------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_write
);

  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              ram_en;
  logic              accept;
  logic [WORD_W-1:0] ram_rdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_write_d = rsp_write_q;
    ram_en      = 1'b0;
    accept      = (state_q == IDLE) && req_valid && req_ready_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          if (ZERO_WAIT) begin
            ram_en      = 1'b1;
            rsp_write_d = req_write;
            state_d     = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ram_en      = 1'b1;
          rsp_write_d = wr_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  // With no wait states the access happens on the accept edge, so the RAM sees the live request.
  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ZERO_WAIT ? req_write : wr_q),
    .be    (ZERO_WAIT ? req_be    : be_q),
    .addr  (ZERO_WAIT ? req_addr  : addr_q),
    .wdata (ZERO_WAIT ? req_wdata : wdata_q),
    .rdata (ram_rdata)
  );

  // The RAM has no reset; gating by registered flags keeps rdata 0 in reset and on stores.
  assign rsp_rdata = (rsp_valid_q && !rsp_write_q) ? ram_rdata : '0;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance,
// scoreboard of expected responses filled as requests are driven.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [9:0]  req_addr  [2];
  logic [3:0]  req_be    [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_write [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [31:0] d;
  } exp_t;
  exp_t        sb_q [$];
  logic [31:0] model_mem [int];

  dmem_responder #(.WAIT_CYCLES(2), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_write(rsp_write[0])
  );

  dmem_responder #(.WAIT_CYCLES(0), .ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_write(rsp_write[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: updates the word image and queues the response it implies.
  task automatic sb_push(input int d, input logic w, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    int key;
    logic [31:0] cur;
    exp_t e;
    key = d * 4096 + int'(a);
    cur = model_mem.exists(key) ? model_mem[key] : 32'h0;
    e.w = w;
    e.d = w ? 32'h0 : cur;
    if (w) begin
      for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
      model_mem[key] = cur;
    end
    sb_q.push_back(e);
  endtask

  // Drives one request and returns when the response was seen (plus one edge).
  task automatic run_txn(input int d, input logic w, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         output int acc, output int rsp, output logic [31:0] rd,
                         output logic rw, output bit to);
    bit got;
    to = 1'b0; acc = -1; rsp = -1; rd = '0; rw = 1'b0;
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a;
    req_be[d] = be; req_wdata[d] = wd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin got = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
    if (!got) begin to = 1'b1; return; end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin got = 1'b1; rsp = cyc; rd = rsp_rdata[d]; rw = rsp_write[d]; end
    end
    if (!got) begin to = 1'b1; return; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_write[d] !== 1'b0) begin
        errors++;
        $display("FAIL in_reset dut%0d: ready=%b valid=%b rdata=%h write=%b, want 0 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_write[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0) begin
          errors++;
          $display("FAIL idle dut%0d cyc%0d: ready=%b valid=%b rdata=%h, want 1 0 0",
                   d, c, req_ready[d], rsp_valid[d], rsp_rdata[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_load();
    int acc1, rsp1, acc2, rsp2;
    logic [31:0] rd;
    logic rw;
    bit to;
    exp_t e;
    sb_push(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    run_txn(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, acc1, rsp1, rd, rw, to);
    e = sb_q.pop_front();
    checks++;
    if (to || rsp1 - acc1 != 3) begin
      errors++;
      $display("FAIL store_latency: got %0d (timeout=%0d), want 3", rsp1 - acc1, to);
    end
    checks++;
    if (rd !== e.d || rw !== e.w) begin
      errors++;
      $display("FAIL store_rsp: rdata=%h write=%b, want %h %b", rd, rw, e.d, e.w);
    end
    sb_push(0, 1'b0, 10'd5, 4'h0, 32'h0);
    run_txn(0, 1'b0, 10'd5, 4'h0, 32'h0, acc2, rsp2, rd, rw, to);
    e = sb_q.pop_front();
    checks++;
    if (to || rsp2 - acc2 != 3) begin
      errors++;
      $display("FAIL load_latency: got %0d (timeout=%0d), want 3", rsp2 - acc2, to);
    end
    checks++;
    if (acc2 - acc1 != 4) begin
      errors++;
      $display("FAIL accept_spacing: got %0d, want 4", acc2 - acc1);
    end
    checks++;
    if (rd !== e.d || rw !== e.w) begin
      errors++;
      $display("FAIL load_rsp: rdata=%h write=%b, want %h %b", rd, rw, e.d, e.w);
    end
  endtask

  task automatic test_byte_enable();
    int acc, rsp;
    logic [31:0] rd;
    logic rw;
    bit to;
    exp_t e;
    logic        w_t  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  be_t [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0};
    logic [31:0] wd_t [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0};
    for (int k = 0; k < 5; k++) begin
      sb_push(0, w_t[k], 10'd7, be_t[k], wd_t[k]);
      run_txn(0, w_t[k], 10'd7, be_t[k], wd_t[k], acc, rsp, rd, rw, to);
      e = sb_q.pop_front();
      checks++;
      if (to || rd !== e.d || rw !== e.w) begin
        errors++;
        $display("FAIL byte_en step%0d: rdata=%h write=%b timeout=%0d, want %h %b",
                 k, rd, rw, to, e.d, e.w);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, rsp;
    logic [31:0] rd;
    logic rw;
    bit to;
    exp_t e;
    rsp_ready[0] = 1'b0;
    sb_push(0, 1'b0, 10'd5, 4'h0, 32'h0);
    run_txn(0, 1'b0, 10'd5, 4'h0, 32'h0, acc, rsp, rd, rw, to);
    e = sb_q.pop_front();
    checks++;
    if (to || rd !== e.d) begin
      errors++;
      $display("FAIL bp_first: rdata=%h timeout=%0d, want %h", rd, to, e.d);
    end
    // A competing store presented while the response stalls must be ignored.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'd5;
    req_be[0] = 4'hF; req_wdata[0] = 32'h0BAD0BAD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.d || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: valid=%b rdata=%h ready=%b, want 1 %h 0",
                 c, rsp_valid[0], rsp_rdata[0], req_ready[0], e.d);
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.d) begin
      errors++;
      $display("FAIL bp_release: valid=%b rdata=%h, want 1 %h", rsp_valid[0], rsp_rdata[0], e.d);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: valid=%b ready=%b, want 0 1", rsp_valid[0], req_ready[0]);
    end
    @(posedge clk); #1;
    sb_push(0, 1'b0, 10'd5, 4'h0, 32'h0);
    run_txn(0, 1'b0, 10'd5, 4'h0, 32'h0, acc, rsp, rd, rw, to);
    e = sb_q.pop_front();
    checks++;
    if (to || rd !== e.d) begin
      errors++;
      $display("FAIL bp_ignored_req: rdata=%h timeout=%0d, want %h", rd, to, e.d);
    end
  endtask

  task automatic test_reset_abort();
    int acc, rsp;
    logic [31:0] rd;
    logic rw;
    bit to;
    bit got;
    exp_t e;
    sb_push(0, 1'b1, 10'd3, 4'hF, 32'h0);
    run_txn(0, 1'b1, 10'd3, 4'hF, 32'h0, acc, rsp, rd, rw, to);
    e = sb_q.pop_front();
    checks++;
    if (to || rw !== e.w) begin
      errors++;
      $display("FAIL abort_prep: write=%b timeout=%0d, want %b", rw, to, e.w);
    end
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 10'd3;
    req_be[0] = 4'hF; req_wdata[0] = 32'h12345678;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[0];
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL abort_accept: request never accepted");
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_write[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: ready=%b valid=%b rdata=%h write=%b, want 0 0 0 0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_write[0]);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    sb_push(0, 1'b0, 10'd3, 4'h0, 32'h0);
    run_txn(0, 1'b0, 10'd3, 4'h0, 32'h0, acc, rsp, rd, rw, to);
    e = sb_q.pop_front();
    checks++;
    if (to || rd !== e.d) begin
      errors++;
      $display("FAIL abort_no_store: rdata=%h timeout=%0d, want %h", rd, to, e.d);
    end
  endtask

  task automatic test_zero_wait();
    int acc [3];
    int rsp [3];
    logic [31:0] rd;
    logic rw;
    bit to;
    exp_t e;
    logic        w_t  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] wd_t [3] = '{32'hCAFEF00D, 32'h0, 32'h01020304};
    for (int k = 0; k < 3; k++) begin
      sb_push(1, w_t[k], 10'd9, 4'hF, wd_t[k]);
      run_txn(1, w_t[k], 10'd9, 4'hF, wd_t[k], acc[k], rsp[k], rd, rw, to);
      e = sb_q.pop_front();
      checks++;
      if (to || rsp[k] - acc[k] != 1 || rd !== e.d || rw !== e.w) begin
        errors++;
        $display("FAIL zw_txn%0d: latency=%0d rdata=%h write=%b timeout=%0d, want 1 %h %b",
                 k, rsp[k] - acc[k], rd, rw, to, e.d, e.w);
      end
      if (k > 0) begin
        checks++;
        if (acc[k] - acc[k-1] != 2) begin
          errors++;
          $display("FAIL zw_spacing%0d: got %0d, want 2", k, acc[k] - acc[k-1]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_be[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
    end
    test_reset();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_reset_abort();
    test_zero_wait();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
